// File: rtl/ddr_security_rd_unmask.sv
// Read-path security unmask: strips the PRNG mask and AES-stub XOR from returning read beats.
// Optional counter-sequence checker enabled by defining DDR_SEC_RD_CTR_CHECK_EN.
module ddr_security_rd_unmask #(
    parameter int DATA_BYTES  = 16,
    parameter int ENABLE_AES  = 1,
    parameter int ENABLE_MASK = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_BYTES*8-1:0]   in_data,
    input  logic [31:0]               in_ctr,
    input  logic                      in_bypass,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_BYTES*8-1:0]   out_data,
    input  logic [127:0]              aes_key,
    input  logic                      key_valid,
    output logic                      key_ack,
    input  logic [127:0]              mask_seed,
    output logic                      busy,
    output logic                      ctr_err
);

    localparam int DATA_W = DATA_BYTES * 8;
    localparam int MASK_W = (DATA_W > 256) ? DATA_W : 256;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // Mask is built 256 bits wide and zero-extended for data buses wider than that.
    function automatic logic [DATA_W-1:0] mask_fn(input logic [127:0] seed,
                                                  input logic [4:0]   sh);
        logic [255:0]      wide;
        logic [MASK_W-1:0] ext;
        wide = {seed, seed} >> sh;
        ext  = MASK_W'(wide);
        return ext[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] decode_fn(input logic [DATA_W-1:0] data,
                                                    input logic [4:0]        sh,
                                                    input logic              byp,
                                                    input logic [127:0]      seed,
                                                    input logic [127:0]      key);
        logic [DATA_W-1:0] d;
        d = data;
        if (!byp) begin
            if (ENABLE_MASK != 0) d = d ^ mask_fn(seed, sh);
            if (ENABLE_AES != 0)  d[127:0] = d[127:0] ^ key;
        end
        return d;
    endfunction

    state_t              state_q;
    state_t              state_d;
    logic [127:0]        key_q;
    logic                rdy_en_q;

    logic                vld_p1;
    logic [DATA_W-1:0]   data_p1;
    logic [4:0]          sh_p1;
    logic                byp_p1;
    logic [127:0]        seed_p1;

    logic                vld_p2;
    logic [DATA_W-1:0]   data_p2;

    logic                s2_take;
    logic                s2_load;
    logic                in_fire;
    logic                drain_done;

    assign s2_take  = !vld_p2 || out_ready;
    assign s2_load  = vld_p1 && s2_take;
    assign in_ready = rdy_en_q && (state_q == ST_RUN) && (!vld_p1 || s2_take);
    assign in_fire  = in_valid && in_ready;

    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign busy      = vld_p1 || vld_p2 || (state_q != ST_RUN);

    // Holds in_ready low while reset is asserted and releases it on the first clock after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en_q <= 1'b0;
        else        rdy_en_q <= 1'b1;
    end

    // Stage 1: capture raw beat and its unmask context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       vld_p1 <= 1'b0;
        else if (in_fire) vld_p1 <= 1'b1;
        else if (s2_load) vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            data_p1 <= in_data;
            sh_p1   <= in_ctr[4:0];
            byp_p1  <= in_bypass;
            seed_p1 <= mask_seed;
        end
    end

    // Stage 2: decode with the current key into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
        end else begin
            if (s2_take) vld_p2 <= vld_p1;
            if (s2_load) data_p2 <= decode_fn(data_p1, sh_p1, byp_p1, seed_p1, key_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    assign drain_done = !vld_p1 && !vld_p2;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (key_valid) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!key_valid)      state_d = ST_RUN;
                else if (drain_done) state_d = ST_LOAD;
            end
            ST_LOAD:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        key_ack = 1'b0;
        if (state_q == ST_LOAD) key_ack = 1'b1;
    end

    // Key only changes with both stages empty, so no beat sees two keys.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 key_q <= '0;
        else if (state_q == ST_LOAD) key_q <= aes_key;
    end

`ifdef DDR_SEC_RD_CTR_CHECK_EN
    logic [31:0] exp_ctr;
    logic        ctr_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_ctr   <= '0;
            ctr_err_q <= 1'b0;
        end else if (in_fire && !in_bypass) begin
            if (in_ctr != exp_ctr) ctr_err_q <= 1'b1;
            exp_ctr <= in_ctr + 32'd1;
        end
    end

    assign ctr_err = ctr_err_q;
`else
    logic ctr_unused;
    assign ctr_unused = ^in_ctr[31:5];
    assign ctr_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_security_rd_unmask.sv
// Directed bench for ddr_security_rd_unmask: decode values, handshake, key-update drain and reset.
module tb_ddr_security_rd_unmask;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [31:0]  in_ctr;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [127:0] aes_key;
    logic         key_valid;
    logic         key_ack;
    logic [127:0] mask_seed;
    logic         busy;
    logic         ctr_err;

    int n_chk = 0;
    int n_pass = 0;

    logic [127:0] got_q[$];
    logic         mon_en = 1'b0;
    logic         tog_en = 1'b0;
    logic         held_v = 1'b0;
    logic [127:0] held_d = '0;
    int           stall_viol = 0;
    int           rdy_viol = 0;

    always #5 clk = ~clk;

    ddr_security_rd_unmask dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctr    (in_ctr),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .aes_key   (aes_key),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .mask_seed (mask_seed),
        .busy      (busy),
        .ctr_err   (ctr_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Output collector and stall/handshake watchers, all sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
        if (mon_en) begin
            if (held_v && !(out_valid && out_data === held_d)) stall_viol++;
            if (!in_ready && !(out_valid && !out_ready)) rdy_viol++;
        end
        held_v = out_valid && !out_ready;
        held_d = out_data;
    end

    always @(posedge clk) begin
        if (tog_en) begin
            #1;
            out_ready = ~out_ready;
        end
    end

    task automatic send(input logic [127:0] d, input logic [31:0] c, input logic b);
        bit acc;
        acc = 1'b0;
        in_data = d; in_ctr = c; in_bypass = b; in_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_chk++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
    endtask

    task automatic wait_out(input int n, input string tag);
        for (int i = 0; i < 60 && got_q.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, 128'(got_q.size()), 128'(n));
    endtask

    task automatic load_key(input logic [127:0] k, input string tag);
        int pulses;
        pulses = 0;
        aes_key = k;
        key_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (key_ack) begin
                pulses++;
                key_valid = 1'b0;
            end
        end
        key_valid = 1'b0;
        @(posedge clk);
        #1;
        chk(tag, 128'(pulses), 128'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] e;
        int           ir_hi;
        int           acks;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctr = '0; in_bypass = 1'b0;
        out_ready = 1'b1; aes_key = '0; key_valid = 1'b0; mask_seed = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_key_ack", 128'(key_ack), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ctr_err", 128'(ctr_err), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);

        // Pass-through with zero key and seed, checking two-cycle latency.
        in_data = {16{8'hA5}}; in_ctr = '0; in_bypass = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_n1_valid", 128'(out_valid), 128'd0);
        chk("lat_n1_busy", 128'(busy), 128'd1);
        @(posedge clk);
        #1;
        chk("lat_n2_valid", 128'(out_valid), 128'd1);
        chk("lat_n2_data", out_data, {16{8'hA5}});
        @(posedge clk);
        #1;
        chk("drained_valid", 128'(out_valid), 128'd0);

        // Key 0F.. applied to all-ones data.
        load_key({16{8'h0F}}, "key0f_ack_pulses");
        got_q.delete();
        send({16{8'hFF}}, 32'd0, 1'b0);
        wait_out(1, "key0f_count");
        chk("key0f_data", got_q[0], {16{8'hF0}});

        // PRNG mask with seed 1, key back to zero.
        load_key(128'd0, "key00_ack_pulses");
        mask_seed = 128'd1;
        got_q.delete();
        send(128'd0, 32'd0, 1'b0);
        send(128'd0, 32'd1, 1'b0);
        send(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 32'd5, 1'b1);
        send(128'h0000_0000_0000_0000_0000_0000_0000_00FF, 32'd4, 1'b0);
        wait_out(4, "mask_count");
        chk("mask_ctr0", got_q[0], 128'h0000_0000_0000_0000_0000_0000_0000_0001);
        chk("mask_ctr1", got_q[1], 128'h8000_0000_0000_0000_0000_0000_0000_0000);
        chk("mask_bypass", got_q[2], 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        chk("mask_ctr4", got_q[3], 128'h1000_0000_0000_0000_0000_0000_0000_00FF);

        // Streaming 8 beats with out_ready toggling every cycle.
        got_q.delete();
        mon_en = 1'b1;
        tog_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = {16{8'(8'h11 * (i + 1))}};
            send(d, 32'(i), 1'b0);
        end
        wait_out(8, "stream_count");
        tog_en = 1'b0;
        mon_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = {16{8'(8'h11 * (i + 1))}};
            e = d ^ ((i == 0) ? 128'd1 : (128'd1 << (128 - i)));
            chk($sformatf("stream_beat%0d", i), got_q[i], e);
        end
        chk("stream_stall_stable", 128'(stall_viol), 128'd0);
        chk("stream_ready_rule", 128'(rdy_viol), 128'd0);

        // Key update requested with two beats stalled in the pipe.
        mask_seed = '0;
        out_ready = 1'b0;
        got_q.delete();
        send({16{8'h12}}, 32'd0, 1'b0);
        send({16{8'h34}}, 32'd0, 1'b0);
        aes_key = {16{8'h3C}};
        key_valid = 1'b1;
        ir_hi = 0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (in_ready) ir_hi++;
        end
        chk("drain_busy", 128'(busy), 128'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && acks == 0; i++) begin
            @(negedge clk);
            if (key_ack) begin
                acks++;
                key_valid = 1'b0;
            end else if (in_ready) begin
                ir_hi++;
            end
        end
        key_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_in_ready_low", 128'(ir_hi), 128'd0);
        chk("drain_key_ack", 128'(acks), 128'd1);
        chk("drain_count", 128'(got_q.size()), 128'd2);
        chk("drain_old_key_a", got_q[0], {16{8'h12}});
        chk("drain_old_key_b", got_q[1], {16{8'h34}});
        send({16{8'h55}}, 32'd0, 1'b0);
        wait_out(3, "newkey_count");
        chk("newkey_data", got_q[2], {16{8'h69}});

        // Asynchronous reset in the middle of a drain.
        out_ready = 1'b0;
        send({16{8'hDE}}, 32'd0, 1'b0);
        send({16{8'hAD}}, 32'd0, 1'b0);
        aes_key = {16{8'h77}};
        key_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_drain_busy", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_drain_out_valid", 128'(out_valid), 128'd0);
        chk("rst_drain_busy", 128'(busy), 128'd0);
        chk("rst_drain_in_ready", 128'(in_ready), 128'd0);
        key_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete();
        send({16{8'hC3}}, 32'd0, 1'b0);
        wait_out(1, "rst_key_count");
        chk("rst_key_cleared", got_q[0], {16{8'hC3}});
        chk("rst_no_key_ack", 128'(key_ack), 128'd0);

`ifdef DDR_SEC_RD_CTR_CHECK_EN
        do_reset();
        send(128'd0, 32'd0, 1'b0);
        send(128'd0, 32'd1, 1'b0);
        chk("ctr_in_order", 128'(ctr_err), 128'd0);
        send(128'd0, 32'd3, 1'b0);
        chk("ctr_gap_err", 128'(ctr_err), 128'd1);
        send(128'd0, 32'd4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("ctr_err_sticky", 128'(ctr_err), 128'd1);
        do_reset();
        chk("ctr_err_reset", 128'(ctr_err), 128'd0);
        send(128'd0, 32'd7, 1'b1);
        chk("ctr_bypass_ignored", 128'(ctr_err), 128'd0);
        chk("ctr_bypass_exp", 128'(dut.exp_ctr), 128'd0);
        send(128'd0, 32'd0, 1'b0);
        chk("ctr_first_ok", 128'(ctr_err), 128'd0);
        send(128'd0, 32'hFFFF_FFFF, 1'b0);
        chk("ctr_wrap_exp", 128'(dut.exp_ctr), 128'd0);
        send(128'd0, 32'd0, 1'b0);
        chk("ctr_after_wrap_exp", 128'(dut.exp_ctr), 128'd1);
`else
        chk("ctr_err_tied", 128'(ctr_err), 128'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
